// File: rtl/motor_sup_pkg.sv
// Shared types and constants for the motor channel supervisor.
package motor_sup_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUN      = 2'd1,
    ST_FAULT    = 2'd2
  } sup_state_e;

  localparam int CAUSE_DRV  = 0;
  localparam int CAUSE_HALL = 1;
  localparam int CAUSE_ENC  = 2;
  localparam int CAUSE_WDT  = 3;
  localparam int CAUSE_W    = 4;

endpackage

// File: rtl/motor_sup_channel.sv
// One supervised channel: run/fault FSM, slew-limited reference, measurement watchdog, cause latch.
// state       | meaning
// ST_DISABLED | idle, iref held at 0, waiting for enable with no raw fault
// ST_RUN      | reference slews toward target on each update_tick
// ST_FAULT    | brake on, iref 0 with a valid per tick, waits for fault_clear
module motor_sup_channel
  import motor_sup_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WDT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  input  logic                  cmd_valid_i,
  input  logic [DATA_WIDTH-1:0] slew_step_i,
  input  logic                  update_tick_i,
  input  logic                  enable_i,
  input  logic                  imeas_valid_i,
  input  logic                  drv_fault_n_i,
  input  logic                  hall_fault_n_i,
  input  logic                  enc_fault_n_i,
  input  logic                  fault_clear_i,
  output logic [DATA_WIDTH-1:0] iref_data_o,
  output logic                  iref_valid_o,
  output logic                  brake_o,
  output logic [CAUSE_W-1:0]    fault_cause_o
);

  localparam int CNT_W = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
  // Trip one count early so the fault lands on the edge where the count reaches WDT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_TRIP = (WDT_CYCLES >= 2) ? CNT_W'(WDT_CYCLES - 2) : '0;
  localparam logic WDT_EN = (WDT_CYCLES != 0);

  sup_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]   tgt_q, tgt_d, iref_q, iref_d, slewed;
  logic                    valid_q, valid_d;
  logic [CAUSE_W-1:0]      cause_q, cause_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              raw;
  logic                    wdt_trip;
  logic signed [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH:0]     diff_abs;

  assign raw      = {~enc_fault_n_i, ~hall_fault_n_i, ~drv_fault_n_i};
  assign tgt_d    = cmd_valid_i ? cmd_data_i : tgt_q;
  assign wdt_trip = WDT_EN && (state_q == ST_RUN) && !imeas_valid_i && (cnt_q >= CNT_TRIP);

  always_comb begin
    diff     = $signed({tgt_d[DATA_WIDTH-1], tgt_d}) - $signed({iref_q[DATA_WIDTH-1], iref_q});
    diff_abs = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    slewed   = tgt_d;
    if (slew_step_i != '0 && diff_abs > {1'b0, slew_step_i}) begin
      slewed = diff[DATA_WIDTH] ? (iref_q - slew_step_i) : (iref_q + slew_step_i);
    end
  end

  always_comb begin
    state_d = state_q;
    iref_d  = '0;
    valid_d = 1'b0;
    cnt_d   = '0;
    cause_d = cause_q;
    cause_d[CAUSE_DRV]  = cause_q[CAUSE_DRV]  | raw[0];
    cause_d[CAUSE_HALL] = cause_q[CAUSE_HALL] | raw[1];
    cause_d[CAUSE_ENC]  = cause_q[CAUSE_ENC]  | raw[2];
    cause_d[CAUSE_WDT]  = cause_q[CAUSE_WDT]  | wdt_trip;
    case (state_q)
      ST_DISABLED: begin
        if (|raw) begin
          state_d = ST_FAULT;
          valid_d = 1'b1;
        end else if (enable_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (|raw || wdt_trip) begin
          state_d = ST_FAULT;
          valid_d = 1'b1;
        end else if (!enable_i) begin
          state_d = ST_DISABLED;
          valid_d = 1'b1;
        end else begin
          iref_d  = update_tick_i ? slewed : iref_q;
          valid_d = update_tick_i;
          if (!imeas_valid_i) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      ST_FAULT: begin
        if (fault_clear_i && !(|raw)) begin
          state_d = ST_DISABLED;
          cause_d = '0;
        end else begin
          valid_d = update_tick_i;
        end
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_DISABLED;
      tgt_q   <= '0;
      iref_q  <= '0;
      valid_q <= 1'b0;
      cause_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      iref_q  <= iref_d;
      valid_q <= valid_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign iref_data_o   = iref_q;
  assign iref_valid_o  = valid_q;
  assign brake_o       = (state_q == ST_FAULT);
  assign fault_cause_o = cause_q;

endmodule

// File: rtl/motor_channel_supervisor.sv
// N-channel current-reference supervisor: per-channel supervision plus packing and global fault.
module motor_channel_supervisor
  import motor_sup_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int WDT_CYCLES = 100000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] cmd_data,
  input  logic [CHANNELS-1:0]            cmd_valid,
  input  logic [DATA_WIDTH-1:0]          slew_step,
  input  logic                           update_tick,
  input  logic [CHANNELS-1:0]            enable,
  input  logic [CHANNELS-1:0]            imeas_valid,
  input  logic [CHANNELS-1:0]            status_driver_fault_n,
  input  logic [CHANNELS-1:0]            status_hall_fault_n,
  input  logic [CHANNELS-1:0]            status_encoder_fault_n,
  input  logic                           fault_clear,
  output logic [CHANNELS*DATA_WIDTH-1:0] iref_data,
  output logic [CHANNELS-1:0]            iref_valid,
  output logic [CHANNELS-1:0]            brake,
  output logic                           fault,
  output logic [CHANNELS*CAUSE_W-1:0]    fault_cause
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    motor_sup_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .WDT_CYCLES (WDT_CYCLES)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .cmd_data_i     (cmd_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .cmd_valid_i    (cmd_valid[c]),
      .slew_step_i    (slew_step),
      .update_tick_i  (update_tick),
      .enable_i       (enable[c]),
      .imeas_valid_i  (imeas_valid[c]),
      .drv_fault_n_i  (status_driver_fault_n[c]),
      .hall_fault_n_i (status_hall_fault_n[c]),
      .enc_fault_n_i  (status_encoder_fault_n[c]),
      .fault_clear_i  (fault_clear),
      .iref_data_o    (iref_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .iref_valid_o   (iref_valid[c]),
      .brake_o        (brake[c]),
      .fault_cause_o  (fault_cause[c*CAUSE_W +: CAUSE_W])
    );
  end

  // A channel brakes exactly when it sits in FAULT.
  assign fault = |brake;

endmodule

// File: tb/tb_motor_channel_supervisor.sv
// Directed plus randomized bench for motor_channel_supervisor against a behavioural channel model.
module tb_motor_channel_supervisor;
  localparam int CH  = 4;
  localparam int DW  = 32;
  localparam int WDT = 16;
  localparam int S_DIS = 0, S_RUN = 1, S_FLT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH*DW-1:0]  cmd_data;
  logic [CH-1:0]     cmd_valid;
  logic [DW-1:0]     slew_step;
  logic              update_tick;
  logic [CH-1:0]     enable;
  logic [CH-1:0]     imeas_valid;
  logic [CH-1:0]     drv_n, hall_n, enc_n;
  logic              fault_clear;
  logic [CH*DW-1:0]  iref_data;
  logic [CH-1:0]     iref_valid;
  logic [CH-1:0]     brake;
  logic              fault;
  logic [CH*4-1:0]   fault_cause;

  motor_channel_supervisor #(.CHANNELS(CH), .DATA_WIDTH(DW), .WDT_CYCLES(WDT)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .cmd_data               (cmd_data),
    .cmd_valid              (cmd_valid),
    .slew_step              (slew_step),
    .update_tick            (update_tick),
    .enable                 (enable),
    .imeas_valid            (imeas_valid),
    .status_driver_fault_n  (drv_n),
    .status_hall_fault_n    (hall_n),
    .status_encoder_fault_n (enc_n),
    .fault_clear            (fault_clear),
    .iref_data              (iref_data),
    .iref_valid             (iref_valid),
    .brake                  (brake),
    .fault                  (fault),
    .fault_cause            (fault_cause)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          m_st[CH];
  longint      m_out[CH];
  longint      m_tgt[CH];
  logic [3:0]  m_cause[CH];
  int          m_wdt[CH];
  logic        m_val[CH];

  task automatic chk(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s ch%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  function automatic logic [63:0] e32(input longint v);
    logic [31:0] t;
    t = 32'(v);
    return {32'b0, t};
  endfunction

  function automatic logic [63:0] iref_of(input int c);
    return {32'b0, iref_data[c*DW +: DW]};
  endfunction

  function automatic logic [63:0] cause_of(input int c);
    return {60'b0, fault_cause[c*4 +: 4]};
  endfunction

  // Channel behaviour from the rules: state, target, slewed output, watchdog age, latched causes.
  task automatic model_update();
    for (int c = 0; c < CH; c++) begin
      logic [2:0] raw;
      logic       tr;
      longint     stp, d, ad;
      raw = {~enc_n[c], ~hall_n[c], ~drv_n[c]};
      if (reset) begin
        m_st[c] = S_DIS; m_out[c] = 0; m_tgt[c] = 0; m_cause[c] = 0; m_wdt[c] = 0; m_val[c] = 0;
        continue;
      end
      if (cmd_valid[c]) m_tgt[c] = longint'($signed(cmd_data[c*DW +: DW]));
      stp = longint'(slew_step);
      m_val[c] = 0;
      case (m_st[c])
        S_DIS: begin
          if (raw != 0) begin
            m_st[c] = S_FLT; m_cause[c] |= {1'b0, raw}; m_out[c] = 0; m_val[c] = 1;
          end else if (enable[c]) begin
            m_st[c] = S_RUN; m_wdt[c] = 0; m_out[c] = 0;
          end
        end
        S_RUN: begin
          tr = !imeas_valid[c] && (m_wdt[c] + 1 >= WDT - 1);
          if (raw != 0 || tr) begin
            m_st[c] = S_FLT; m_cause[c] |= {tr, raw}; m_out[c] = 0; m_val[c] = 1;
          end else if (!enable[c]) begin
            m_st[c] = S_DIS; m_out[c] = 0; m_val[c] = 1;
          end else begin
            m_wdt[c] = imeas_valid[c] ? 0 : m_wdt[c] + 1;
            if (update_tick) begin
              d  = m_tgt[c] - m_out[c];
              ad = (d < 0) ? -d : d;
              if (stp == 0 || ad <= stp) m_out[c] = m_tgt[c];
              else if (d > 0)            m_out[c] = m_out[c] + stp;
              else                       m_out[c] = m_out[c] - stp;
              m_val[c] = 1;
            end
          end
        end
        default: begin
          m_cause[c] |= {1'b0, raw};
          m_out[c] = 0;
          if (fault_clear && raw == 0) begin
            m_st[c] = S_DIS; m_cause[c] = 0;
          end else begin
            m_val[c] = update_tick;
          end
        end
      endcase
    end
  endtask

  task automatic check_all();
    logic any;
    any = 0;
    for (int c = 0; c < CH; c++) begin
      chk("iref", c, iref_of(c), e32(m_out[c]));
      chk("valid", c, 64'(iref_valid[c]), 64'(m_val[c]));
      chk("brake", c, 64'(brake[c]), 64'(m_st[c] == S_FLT));
      chk("cause", c, cause_of(c), {60'b0, m_cause[c]});
      if (m_st[c] == S_FLT) any = 1;
    end
    chk("fault", 0, 64'(fault), 64'(any));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
    cmd_valid   = '0;
    update_tick = 1'b0;
    fault_clear = 1'b0;
  endtask

  task automatic set_cmd(input int c, input logic [31:0] v);
    cmd_data[c*DW +: DW] = v;
    cmd_valid[c] = 1'b1;
  endtask

  initial begin
    int neg_exp[3];
    neg_exp = '{500, 0, -250};
    reset = 1'b1; cmd_data = '0; cmd_valid = '0; slew_step = '0; update_tick = 1'b0;
    enable = '0; imeas_valid = '1; drv_n = '1; hall_n = '1; enc_n = '1; fault_clear = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_st[c] = S_DIS; m_out[c] = 0; m_tgt[c] = 0; m_cause[c] = 0; m_wdt[c] = 0; m_val[c] = 0;
    end
    repeat (3) step();
    reset = 1'b0;
    step();

    // Positive ramp
    slew_step = 32'd100; enable[0] = 1'b1; step();
    set_cmd(0, 32'd1000); step();
    for (int k = 1; k <= 12; k++) begin
      update_tick = 1'b1; step();
      chk("ramp", 0, iref_of(0), e32((k >= 10) ? 1000 : k * 100));
      chk("ramp_valid", 0, 64'(iref_valid[0]), 64'(1));
      step();
    end

    // Negative ramp
    slew_step = 32'd500; set_cmd(0, -32'sd250); step();
    for (int k = 0; k < 3; k++) begin
      update_tick = 1'b1; step();
      chk("neg_ramp", 0, iref_of(0), e32(neg_exp[k]));
    end

    // Unlimited slew across full range
    slew_step = '0; set_cmd(0, 32'h8000_0000); update_tick = 1'b1; step();
    chk("unlim_min", 0, iref_of(0), 64'h0000_0000_8000_0000);
    set_cmd(0, 32'h7FFF_FFFF); update_tick = 1'b1; step();
    chk("unlim_max", 0, iref_of(0), 64'h0000_0000_7FFF_FFFF);

    // Hall fault on ch2 and clear
    enable[2] = 1'b1; step();
    set_cmd(2, 32'd300); update_tick = 1'b1; step();
    hall_n[2] = 1'b0; step();
    chk("hall_brake", 2, 64'(brake[2]), 64'(1));
    chk("hall_fault", 2, 64'(fault), 64'(1));
    chk("hall_cause", 2, cause_of(2), 64'(4'b0010));
    chk("hall_iref", 2, iref_of(2), 64'(0));
    chk("hall_valid", 2, 64'(iref_valid[2]), 64'(1));
    fault_clear = 1'b1; step();
    chk("clear_ignored", 2, cause_of(2), 64'(4'b0010));
    hall_n[2] = 1'b1; step();
    fault_clear = 1'b1; step();
    chk("clear_brake", 2, 64'(brake[2]), 64'(0));
    chk("clear_cause", 2, cause_of(2), 64'(0));
    enable[2] = 1'b0; step();

    // Watchdog trips on ch1 with no measurements
    enable[0] = 1'b0; step();
    imeas_valid[1] = 1'b0; enable[1] = 1'b1; step();
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("wdt_trip", 1, 64'(fault_cause[1*4 + 3]), 64'(k == 15));
    end
    enable[1] = 1'b0; fault_clear = 1'b1; step();
    enable[1] = 1'b1; step();
    for (int k = 1; k <= 60; k++) begin
      imeas_valid[1] = (k % 10 == 0);
      step();
      chk("wdt_hold", 1, 64'(fault_cause[1*4 + 3]), 64'(0));
    end
    imeas_valid = '1; enable[1] = 1'b0; step();

    // Fault coincident with tick
    enable[0] = 1'b1; step();
    slew_step = 32'd50; set_cmd(0, 32'd1000); update_tick = 1'b1; step();
    chk("pre_fault", 0, iref_of(0), 64'(50));
    drv_n[0] = 1'b0; update_tick = 1'b1; step();
    chk("fault_tick_iref", 0, iref_of(0), 64'(0));
    chk("fault_tick_cause", 0, cause_of(0), 64'(4'b0001));
    drv_n[0] = 1'b1; fault_clear = 1'b1; step();

    // Reset mid-ramp
    step();
    update_tick = 1'b1; step();
    update_tick = 1'b1; step();
    chk("pre_reset", 0, iref_of(0), 64'(100));
    reset = 1'b1; update_tick = 1'b1; step();
    chk("reset_iref", 0, iref_of(0), 64'(0));
    chk("reset_valid", 0, 64'(iref_valid[0]), 64'(0));
    reset = 1'b0; step();

    // Randomized traffic; ch3 gets sparse measurements so its watchdog trips
    enable = '1; slew_step = 32'd200;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(3) == 0) begin
          cmd_data[c*DW +: DW] = ($urandom_range(1) == 1) ? $urandom : 32'($urandom_range(4000)) - 32'd2000;
          cmd_valid[c] = 1'b1;
        end
        if ($urandom_range(15) == 0) enable[c] = ~enable[c];
        imeas_valid[c] = (c == 3) ? ($urandom_range(15) == 0) : ($urandom_range(3) != 0);
        drv_n[c]  = ($urandom_range(99) != 0);
        hall_n[c] = ($urandom_range(99) != 0);
        enc_n[c]  = ($urandom_range(99) != 0);
      end
      update_tick = ($urandom_range(2) == 0);
      fault_clear = ($urandom_range(7) == 0);
      reset       = ($urandom_range(299) == 0);
      if ($urandom_range(31) == 0) begin
        case ($urandom_range(2))
          0: slew_step = '0;
          1: slew_step = 32'($urandom_range(500));
          default: slew_step = $urandom;
        endcase
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
